// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game-flow controller.
//   state_t  : one-hot game state (START, PLAY, END)
//   BCD_W    : width of one BCD digit
//   SCORE_W  : width of a 3-digit BCD score
//   TIME_W   : width of the 2-digit BCD round timer
package game_flow_ctrl_pkg;

    localparam int BCD_W   = 4;
    localparam int SCORE_W = 3 * BCD_W;
    localparam int TIME_W  = 2 * BCD_W;

    // One-hot: bit 0 = START, bit 1 = PLAY, bit 2 = END. The screen enables
    // are taken straight from these flop bits.
    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

endpackage

// File: rtl/game_flow_ctrl_bcd3_step.sv
// bcd3_step: combinational single step on a 3-digit BCD value.
//   val       in  12  BCD value [11:8] hundreds, [7:4] tens, [3:0] units
//   dec       in  1   1 = decrement (floors at 000), 0 = increment
//   two_digit in  1   increment saturates at 99 instead of 999
//   result    out 12  stepped BCD value
module bcd3_step
    import game_flow_ctrl_pkg::*;
(
    input  logic [SCORE_W-1:0] val,
    input  logic               dec,
    input  logic               two_digit,
    output logic [SCORE_W-1:0] result
);

    logic [BCD_W-1:0] d0, d1, d2;
    logic             at_max;

    assign d0 = val[3:0];
    assign d1 = val[7:4];
    assign d2 = val[11:8];

    assign at_max = two_digit ? (val[7:0] == 8'h99) : (val == 12'h999);

    always_comb begin
        result = val;
        if (dec) begin
            if (val != '0) begin
                if (d0 != 4'd0) begin
                    result[3:0] = d0 - 4'd1;
                end else begin
                    result[3:0] = 4'd9;
                    if (d1 != 4'd0) begin
                        result[7:4] = d1 - 4'd1;
                    end else begin
                        result[7:4]  = 4'd9;
                        result[11:8] = d2 - 4'd1;
                    end
                end
            end
        end else if (!at_max) begin
            if (d0 != 4'd9) begin
                result[3:0] = d0 + 4'd1;
            end else begin
                result[3:0] = 4'd0;
                if (d1 != 4'd9) begin
                    result[7:4] = d1 + 4'd1;
                end else begin
                    result[7:4]  = 4'd0;
                    result[11:8] = d2 + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: START -> PLAY -> END sequencing for the jump game.
//   clk           in  system (pixel) clock
//   rst           in  asynchronous active-low reset
//   start         in  spacebar press pulse
//   jump_start    in  a jump begins (pulse)
//   jump_fail_in  in  player fell (pulse)
//   start_en      out start-screen enable (START)
//   game_en       out game-renderer enable (PLAY)
//   end_en        out end-screen enable (END)
//   jump_fail     out round ended by a fall
//   one_sec_tick  out one-cycle pulse every CLK_HZ cycles
//   score         out 3-digit BCD jump count
//   best_score    out best corrected score, BCD
//   time_left     out 2-digit BCD seconds remaining
//   state_dbg     out raw one-hot state register
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int          CLK_HZ       = 65_000_000,
    parameter logic [7:0]  GAME_SECONDS = 8'h60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        jump_start,
    input  logic        jump_fail_in,
    output logic        start_en,
    output logic        game_en,
    output logic        end_en,
    output logic        jump_fail,
    output logic        one_sec_tick,
    output logic [11:0] score,
    output logic [11:0] best_score,
    output logic [7:0]  time_left,
    output logic [2:0]  state_dbg
);

    localparam int              DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   best_q, best_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic                 fail_q, fail_d;
    logic [1:0]           end_cnt_q, end_cnt_d;
    logic [DIV_W-1:0]     div_q, div_nxt;
    logic                 tick_q;
    logic                 div_clr;

    logic [SCORE_W-1:0]   score_inc;
    logic [SCORE_W-1:0]   play_score_nxt;
    logic [SCORE_W-1:0]   corr_dec;
    logic [SCORE_W-1:0]   corrected;
    logic [SCORE_W-1:0]   time_dec;

    // ---------------- BCD arithmetic ----------------
    bcd3_step u_score_inc (
        .val       (score_q),
        .dec       (1'b0),
        .two_digit (1'b0),
        .result    (score_inc)
    );

    // A fall overrides a same-cycle jump, so the jump is not counted.
    assign play_score_nxt = (jump_start && !jump_fail_in) ? score_inc : score_q;

    // The falling jump was already counted; the best score uses score-1.
    bcd3_step u_corr_dec (
        .val       (play_score_nxt),
        .dec       (1'b1),
        .two_digit (1'b0),
        .result    (corr_dec)
    );

    assign corrected = jump_fail_in ? corr_dec : play_score_nxt;

    bcd3_step u_time_dec (
        .val       ({4'h0, time_q}),
        .dec       (1'b1),
        .two_digit (1'b1),
        .result    (time_dec)
    );

    // ---------------- one-second divider ----------------
    assign div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    // tick_q is high exactly while div_q == DIV_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_clr) begin
            div_q  <= '0;
            tick_q <= (DIV_LAST == '0);
        end else begin
            div_q  <= div_nxt;
            tick_q <= (div_nxt == DIV_LAST);
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_START;
            score_q   <= '0;
            best_q    <= '0;
            time_q    <= GAME_SECONDS;
            fail_q    <= 1'b0;
            end_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            best_q    <= best_d;
            time_q    <= time_d;
            fail_q    <= fail_d;
            end_cnt_q <= end_cnt_d;
        end
    end

    // ---------------- next state / holding registers ----------------
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        best_d    = best_q;
        time_d    = time_q;
        fail_d    = fail_q;
        end_cnt_d = end_cnt_q;
        div_clr   = 1'b0;

        unique case (state_q)
            ST_START: begin
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    time_d  = GAME_SECONDS;
                    fail_d  = 1'b0;
                    div_clr = 1'b1;
                end
            end

            ST_PLAY: begin
                if (jump_fail_in) begin
                    state_d = ST_END;
                    fail_d  = 1'b1;
                    div_clr = 1'b1;
                end else begin
                    score_d = play_score_nxt;
                    if (tick_q) begin
                        time_d = time_dec[7:0];
                        if (time_dec == '0) begin
                            state_d = ST_END;
                            fail_d  = 1'b0;
                            div_clr = 1'b1;
                        end
                    end
                end
                if (state_d == ST_END) begin
                    end_cnt_d = '0;
                    // BCD digits order the same as binary, so a plain compare works.
                    if (corrected > best_q) begin
                        best_d = corrected;
                    end
                end
            end

            ST_END: begin
                // Ignore start until two ticks have passed so the press that
                // ended the round cannot immediately restart it.
                if (tick_q && end_cnt_q != 2'd2) begin
                    end_cnt_d = end_cnt_q + 2'd1;
                end
                if (start && end_cnt_q == 2'd2) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign start_en     = state_q[0];
    assign game_en      = state_q[1];
    assign end_en       = state_q[2];
    assign state_dbg    = state_q;
    assign jump_fail    = fail_q;
    assign one_sec_tick = tick_q;
    assign score        = score_q;
    assign best_score   = best_q;
    assign time_left    = time_q;

endmodule
